// File: rtl/actor_token_fifo.sv
// actor_token_fifo
// ----------------
// Token channel between a producer actor's Out-port and a consumer actor's
// In-port. Buffers up to DEPTH tokens so the two actors fire independently.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RESET       asynchronous, active-high reset (released synchronously by
//               the surrounding reset logic)
//   Din_DATA    token from the producer
//   Din_SEND    producer offers a token this cycle
//   Din_COUNT   tokens per send; always 1, not used for control
//   Din_RDY     FIFO can accept a token (from registered occupancy only)
//   Din_ACK     token on Din_DATA accepted this cycle
//   Dout_DATA   head token, valid whenever Dout_SEND=1 (0 while empty)
//   Dout_SEND   head token valid
//   Dout_COUNT  occupancy, zero-extended to 16 bits
//   Dout_ACK    consumer takes the head token this cycle
//   Err         (only with ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN) sticky
//               protocol errors: [0] send while not ready, [1] ack while
//               empty; cleared only by RESET
//
// Build option: define ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN to add the Err
// port and its two sticky flops. Without it, violations are silently
// dropped/ignored and no extra state exists.

module actor_token_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] Din_DATA,
    input  logic                  Din_SEND,
    input  logic [15:0]           Din_COUNT,
    output logic                  Din_RDY,
    output logic                  Din_ACK,
    output logic [DATA_WIDTH-1:0] Dout_DATA,
    output logic                  Dout_SEND,
    output logic [15:0]           Dout_COUNT,
    input  logic                  Dout_ACK
`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
    ,
    output logic [1:0]            Err
`endif
);

    localparam logic [ADDR_WIDTH:0]   OCC_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   OCC_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   occ;

    logic push;
    logic pop;

    // Token count is fixed at one per send, so the field carries no control.
    logic unused_din_count;
    assign unused_din_count = ^Din_COUNT;

    // Ready looks only at registered occupancy, so a full FIFO never accepts
    // a token even when the consumer pops in the same cycle.
    assign Din_RDY   = (occ != OCC_FULL) & ~RESET;
    assign push      = Din_SEND & Din_RDY;
    assign Din_ACK   = push;

    assign Dout_SEND = (occ != '0);
    assign pop       = Dout_ACK & Dout_SEND;

    // Head entry is read straight from storage at the registered read
    // pointer; forced to zero while empty so reset and idle show 0 rather
    // than stale or uninitialised storage.
    assign Dout_DATA  = Dout_SEND ? mem[rd_ptr] : '0;
    assign Dout_COUNT = {{(16 - ADDR_WIDTH - 1){1'b0}}, occ};

    // Storage: data only, never reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= Din_DATA;
        end
    end

    // Control: pointers and occupancy
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
    // Sticky protocol error flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Err <= 2'b00;
        end else begin
            Err[0] <= Err[0] | (Din_SEND & ~Din_RDY);
            Err[1] <= Err[1] | (Dout_ACK & ~Dout_SEND);
        end
    end
`endif

endmodule
